// File: rtl/led_panel_pkg.sv
// Shared encodings for the UART LED-panel command parser: opcodes, command
// nibbles, the abort byte, the power-up colour and the parser state type.
package led_panel_pkg;

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_CLS = 2'b10;

  localparam logic [3:0] NIB_RGB = 4'h0;
  localparam logic [3:0] NIB_SET = 4'h1;
  localparam logic [3:0] NIB_CLR = 4'h2;
  localparam logic [3:0] NIB_CLS = 4'h3;
  localparam logic [3:0] NIB_NOP = 4'hF;

  localparam logic [7:0] ABORT_BYTE  = 8'hFF;
  localparam logic [2:0] DEFAULT_RGB = 3'b011;

  localparam int unsigned CMD_W = 10;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SET = 2'd1,
    ST_WAIT_CLR = 2'd2
  } parser_state_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte input, command output handshake and status signals of the parser.
// slave is the parser's view, master the driver/consumer's view.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [2:0] rgb;
  logic       fifo_full;
  logic [7:0] overflow_cnt;
  logic       timeout_pulse;

  modport master (
    output rx_data, rx_dv, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, rgb, fifo_full, overflow_cnt, timeout_pulse
  );

  modport slave (
    input  rx_data, rx_dv, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, rgb, fifo_full, overflow_cnt, timeout_pulse
  );
endinterface

// File: rtl/cmd_fifo.sv
// First-word fall-through command queue; DEPTH must be a power of two so the
// pointers wrap naturally. A push into a full queue is taken only with a pop.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; empty_o qualifies the head, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes UART bytes into LED-panel commands queued in a cmd_fifo.
// Define UART_CMD_PARSER_TIMEOUT_EN to abort an address wait after TIMEOUT_CLKS idle clocks.
module uart_cmd_parser
  import led_panel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two from 2 to 16");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  parser_state_e state_q, state_d;
  logic [2:0]    rgb_q, rgb_d;
  logic [7:0]    overflow_q;
  logic          push, pop, drop, timeout_fire;
  logic          fifo_full, fifo_empty;
  cmd_t          push_cmd, head;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rgb_d    = rgb_q;
    push     = 1'b0;
    push_cmd = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_dv) begin
          case (bus.rx_data[7:4])
            NIB_RGB: rgb_d   = bus.rx_data[2:0];
            NIB_SET: state_d = ST_WAIT_SET;
            NIB_CLR: state_d = ST_WAIT_CLR;
            NIB_CLS: begin
              push        = 1'b1;
              push_cmd.op = OP_CLS;
            end
            NIB_NOP: ;
            default: ;
          endcase
        end
      end
      ST_WAIT_SET, ST_WAIT_CLR: begin
        if (bus.rx_dv) begin
          state_d = ST_IDLE;
          if (bus.rx_data != ABORT_BYTE) begin
            push          = 1'b1;
            push_cmd.op   = (state_q == ST_WAIT_SET) ? OP_SET : OP_CLR;
            push_cmd.addr = bus.rx_data;
          end
        end else if (timeout_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_pulse_q;

  // Held at zero while idle, so every address wait starts counting from zero.
  always_comb begin
    tmo_cnt_d    = tmo_cnt_q;
    timeout_fire = 1'b0;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (!bus.rx_dv) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
        timeout_fire = 1'b1;
        tmo_cnt_d    = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q       <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_pulse_q <= timeout_fire;
    end
  end

  assign bus.timeout_pulse = timeout_pulse_q;
`else
  assign timeout_fire      = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  assign pop  = !fifo_empty && bus.cmd_ready;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rgb_q      <= DEFAULT_RGB;
      overflow_q <= '0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      if (drop && overflow_q != 8'hFF) overflow_q <= overflow_q + 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Head fields read as zero whenever the queue is empty, including out of reset.
  assign bus.cmd_valid    = !fifo_empty;
  assign bus.cmd_op       = fifo_empty ? 2'b00 : head.op;
  assign bus.cmd_addr     = fifo_empty ? 8'h00 : head.addr;
  assign bus.rgb          = rgb_q;
  assign bus.fifo_full    = fifo_full;
  assign bus.overflow_cnt = overflow_q;
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the decoded-command queue depth; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4096, meaning the idle clocks allowed between a SET/CLR opcode byte and its address byte.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_dv  input  1  one-cycle strobe; rx_data is valid only when rx_dv=1.
REQ-007 cmd_valid  output  1  queue head is valid.
REQ-008 cmd_ready  input  1  downstream consumer accepts the head.
REQ-009 cmd_op  output  2  head opcode: 00 set pixel, 01 clear pixel, 10 clear screen, 11 reserved (never produced).
REQ-010 cmd_addr  output  8  head pixel address: [7:4] column, [3:0] row; 0 for clear screen.
REQ-011 rgb  output  3  current draw colour {r,g,b}.
REQ-012 fifo_full  output  1  queue holds FIFO_DEPTH entries.
REQ-013 overflow_cnt  output  8  count of dropped commands, saturating.
REQ-014 timeout_pulse  output  1  one-cycle flag marking an address-wait abort.

Function
REQ-015 Parser states SHALL be IDLE, WAIT_SET and WAIT_CLR, and bytes SHALL be acted on only in cycles where rx_dv=1.
REQ-016 IDLE actions SHALL be selected by rx_data[7:4]: 0x0 sets rgb<=rx_data[2:0] on the next edge with nothing queued; 0x1 goes to WAIT_SET; 0x2 goes to WAIT_CLR; 0x3 pushes op 10; 0xF stays in IDLE; every other nibble is ignored.
REQ-017 In WAIT_SET or WAIT_CLR, byte 0xFF SHALL return the parser to IDLE with no push; any other byte SHALL push op 00 (WAIT_SET) or 01 (WAIT_CLR) with cmd_addr=rx_data, and the parser SHALL return to IDLE.
REQ-018 Latency: a push at edge N into an empty queue SHALL drive cmd_valid=1 with the matching cmd_op/cmd_addr after edge N (first-word fall-through).
REQ-019 The head SHALL pop on a rising edge only when cmd_valid and cmd_ready are both 1, and cmd_op/cmd_addr SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-020 A push SHALL be accepted when count<FIFO_DEPTH, or when the queue is full and a pop occurs in the same cycle; otherwise the command SHALL be dropped and overflow_cnt SHALL increment, holding at 255.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A dropped command SHALL still return the parser to IDLE.

Reset
REQ-023 Asserting reset SHALL set, immediately and asynchronously: state IDLE, queue empty, cmd_valid=0, cmd_op=00, cmd_addr=0, rgb=3'b011, fifo_full=0, overflow_cnt=0, timeout_pulse=0, timeout counter=0.
REQ-024 Reset asserted mid-command SHALL discard any pending opcode and all queued entries; the first byte after release SHALL be decoded from IDLE.

Configuration
REQ-025 Macro UART_CMD_PARSER_TIMEOUT_EN SHALL control the address-wait timeout.
REQ-026 When the macro is defined, a counter SHALL clear on entry to WAIT_SET or WAIT_CLR and increment on every cycle there without rx_dv; when it reaches TIMEOUT_CLKS-1, the parser SHALL go to IDLE with no push and timeout_pulse=1 for one cycle; if rx_dv=1 arrives in that same cycle, the byte SHALL win and the timeout SHALL not fire.
REQ-027 When the macro is undefined, no counter SHALL exist, the parser SHALL wait indefinitely and timeout_pulse SHALL be tied to 0.

Structure
REQ-028 Package led_panel_pkg SHALL hold the opcode encodings (OP_SET, OP_CLR, OP_CLS), the command nibbles (0x0/0x1/0x2/0x3/0xF), the abort byte 0xFF, DEFAULT_RGB=3'b011 and the parser state enum.
REQ-029 The queue SHALL be a sub-module cmd_fifo, parameterised by depth and a 10-bit width ({op,addr}), providing first-word fall-through, full and empty.

Verification
REQ-030 Bytes 0x10 then 0x5A with cmd_ready=1 -> one cycle of cmd_valid=1 with cmd_op=00 and cmd_addr=0x5A; overflow_cnt stays 0.
REQ-031 Byte 0x05 -> rgb=3'b101 on the next cycle and cmd_valid stays 0; then reset -> rgb=3'b011.
REQ-032 Bytes 0x20 then 0xFF -> no push and state IDLE; then 0x30 -> cmd_op=10, cmd_addr=0x00.
REQ-033 cmd_ready=0 and 6 SET commands with FIFO_DEPTH=4 -> fifo_full=1, overflow_cnt=2, and pops return the first 4 addresses in order.
REQ-034 Full queue with cmd_ready=1 and a push in the same cycle -> push accepted, count stays 4, overflow_cnt unchanged.
REQ-035 With UART_CMD_PARSER_TIMEOUT_EN and TIMEOUT_CLKS=16: byte 0x10 followed by 16 idle clocks -> timeout_pulse=1 for one cycle, then 0x33 -> a clear-screen push rather than a pixel set.
